// File: rtl/blk_addr_alloc.sv
// blk_addr_alloc: shared free-list allocator of 16-word SRAM blocks with round-robin grant
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_addr_req          per-port one-cycle request pulses (one block each)
//   o_blk_addr_vld      one-hot grant, high for one cycle
//   o_blk_addr          granted block address {idx, 4'b0}, 0 when no grant
//   i_rel_vld           block release strobe
//   i_rel_addr          released block address, bits [3:0] ignored
//   o_free_cnt          number of free blocks
//   o_ready             free list built, allocator serving requests
//   o_err               sticky error: duplicate request or dropped release
module blk_addr_alloc #(
   parameter int N_PORTS        = 4,
   parameter int BLK_ADDR_WIDTH = 11
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [N_PORTS-1:0]        i_addr_req,
   output logic [N_PORTS-1:0]        o_blk_addr_vld,
   output logic [BLK_ADDR_WIDTH-1:0] o_blk_addr,
   input  logic                      i_rel_vld,
   input  logic [BLK_ADDR_WIDTH-1:0] i_rel_addr,
   output logic [BLK_ADDR_WIDTH-4:0] o_free_cnt,
   output logic                      o_ready,
   output logic                      o_err
);
   localparam int IDX_W    = BLK_ADDR_WIDTH - 4;
   localparam int NUM_BLKS = 2 ** IDX_W;
   localparam int CNT_W    = IDX_W + 1;
   localparam int PW       = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_BLKS);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t             state;
   logic [IDX_W-1:0]   fifo [NUM_BLKS];
   logic [IDX_W-1:0]   rd_ptr, wr_ptr;
   logic [CNT_W-1:0]   count;
   logic [N_PORTS-1:0] pend, gnt;
   logic [PW-1:0]      rr_ptr, gnt_idx;
   logic               can_gnt, gnt_any, push, rel_err, dup, we;
   logic [IDX_W-1:0]   wdata;
   logic               unused_lo;

   function automatic int wrap(input int a);
      return a % N_PORTS;
   endfunction

   assign unused_lo  = ^i_rel_addr[3:0];
   assign o_free_cnt = count;
   assign o_ready    = state == S_RUN;
   assign can_gnt    = state == S_RUN && count != '0;
   assign gnt_any    = |gnt;
   assign dup        = |(pend & i_addr_req);
   assign push       = i_rel_vld && state == S_RUN && count != FULL;
   assign rel_err    = i_rel_vld && (state == S_INIT || count == FULL);
   // init writes its own index sequence through the same write port as releases
   assign we         = state == S_INIT || push;
   assign wdata      = state == S_INIT ? wr_ptr : i_rel_addr[BLK_ADDR_WIDTH-1:4];

   // descending scan so the pending port closest to rr_ptr is the last, winning assignment
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         if (can_gnt && pend[wrap(int'(rr_ptr) + i)]) begin
            gnt                          = '0;
            gnt[wrap(int'(rr_ptr) + i)]  = 1'b1;
            gnt_idx                      = PW'(wrap(int'(rr_ptr) + i));
         end
      end
   end

   always_ff @(posedge i_clk)
      if (we) fifo[wr_ptr] <= wdata;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= S_INIT;
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
         pend           <= '0;
         rr_ptr         <= '0;
         o_blk_addr_vld <= '0;
         o_blk_addr     <= '0;
         o_err          <= 1'b0;
      end else begin
         o_blk_addr_vld <= gnt;
         o_blk_addr     <= gnt_any ? {fifo[rd_ptr], 4'b0} : '0;
         pend           <= (pend | i_addr_req) & ~gnt;
         o_err          <= o_err | dup | rel_err;
         if (gnt_any) begin
            rd_ptr <= rd_ptr + 1'b1;
            rr_ptr <= PW'(wrap(int'(gnt_idx) + 1));
         end
         if (we) wr_ptr <= wr_ptr + 1'b1;
         count <= count + CNT_W'(we) - CNT_W'(gnt_any);
         if (state == S_INIT && wr_ptr == '1) state <= S_RUN;
      end
   end
endmodule

// File: tb/tb_blk_addr_alloc.sv
// tb_blk_addr_alloc: directed and random checks of blk_addr_alloc against a queue-based free-list model
module tb_blk_addr_alloc;
   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [3:0]  i_addr_req = '0;
   logic [3:0]  o_blk_addr_vld;
   logic [10:0] o_blk_addr;
   logic        i_rel_vld = 1'b0;
   logic [10:0] i_rel_addr = '0;
   logic [7:0]  o_free_cnt;
   logic        o_ready;
   logic        o_err;

   int passed = 0;
   int total  = 0;

   int        q[$];
   bit [3:0]  m_pend;
   int        m_rr, m_init;
   bit        m_err, m_ready;
   bit [3:0]  m_vld;
   bit [10:0] m_addr;

   blk_addr_alloc dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_addr_req     (i_addr_req),
      .o_blk_addr_vld (o_blk_addr_vld),
      .o_blk_addr     (o_blk_addr),
      .i_rel_vld      (i_rel_vld),
      .i_rel_addr     (i_rel_addr),
      .o_free_cnt     (o_free_cnt),
      .o_ready        (o_ready),
      .o_err          (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      i_rst_n    = 1'b0;
      i_addr_req = '0;
      i_rel_vld  = 1'b0;
      q.delete();
      m_pend = '0; m_rr = 0; m_init = 0; m_err = 0; m_ready = 0; m_vld = '0; m_addr = '0;
      #1;
      chk("rst_vld", 32'(o_blk_addr_vld), 0);
      chk("rst_addr", 32'(o_blk_addr), 0);
      chk("rst_cnt", 32'(o_free_cnt), 0);
      chk("rst_ready", 32'(o_ready), 0);
      chk("rst_err", 32'(o_err), 0);
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   // one clock cycle: drive inputs, advance the model, then compare every output
   task automatic step(input bit [3:0] req, input bit rv = 0, input bit [10:0] ra = '0);
      int g, n;
      i_addr_req = req;
      i_rel_vld  = rv;
      i_rel_addr = ra;
      g = -1;
      n = q.size();
      if ((m_pend & req) != 0) m_err = 1;
      if (m_ready && n > 0)
         for (int i = 0; i < 4; i++)
            if (g < 0 && m_pend[(m_rr + i) % 4]) g = (m_rr + i) % 4;
      m_vld  = g >= 0 ? 4'(1 << g) : 4'd0;
      m_addr = g >= 0 ? 11'(q[0] * 16) : 11'd0;
      if (!m_ready) begin
         if (rv) m_err = 1;
         q.push_back(m_init);
         m_init++;
         if (m_init == 128) m_ready = 1;
      end else begin
         if (g >= 0) void'(q.pop_front());
         if (rv) begin
            if (n == 128) m_err = 1;
            else q.push_back(int'(ra[10:4]));
         end
      end
      m_pend = (m_pend | req) & ~m_vld;
      if (g >= 0) m_rr = (g + 1) % 4;
      @(posedge i_clk);
      #1;
      chk("vld", 32'(o_blk_addr_vld), 32'(m_vld));
      chk("addr", 32'(o_blk_addr), 32'(m_addr));
      chk("free_cnt", 32'(o_free_cnt), 32'(q.size()));
      chk("ready", 32'(o_ready), 32'(m_ready));
      chk("err", 32'(o_err), 32'(m_err));
      i_addr_req = '0;
      i_rel_vld  = 1'b0;
   endtask

   initial begin
      // idle init, then a single port-0 request
      do_reset();
      for (int i = 0; i < 128; i++) step(4'b0000);
      chk("init_ready", 32'(o_ready), 1);
      chk("init_cnt", 32'(o_free_cnt), 128);
      step(4'b0001);
      step(4'b0000);
      chk("p0_vld", 32'(o_blk_addr_vld), 32'h1);
      chk("p0_addr", 32'(o_blk_addr), 32'h000);
      step(4'b0000);
      chk("p0_cnt", 32'(o_free_cnt), 127);

      // all ports at once, then round-robin order, drain, empty list, release
      do_reset();
      for (int i = 0; i < 128; i++) step(4'b0000);
      step(4'b1111);
      for (int i = 0; i < 4; i++) begin
         step(4'b0000);
         chk("all_vld", 32'(o_blk_addr_vld), 32'(1 << i));
         chk("all_addr", 32'(o_blk_addr), 32'(i * 16));
      end
      step(4'b1010);
      step(4'b0000);
      chk("rr_first", 32'(o_blk_addr_vld), 32'b0010);
      step(4'b0000);
      chk("rr_second", 32'(o_blk_addr_vld), 32'b1000);
      for (int i = 0; i < 122; i++) step(i % 2 ? 4'b0010 : 4'b0001);
      step(4'b0000);
      chk("drain_cnt", 32'(o_free_cnt), 0);
      step(4'b0100);
      for (int i = 0; i < 3; i++) begin
         step(4'b0000);
         chk("empty_nogrant", 32'(o_blk_addr_vld), 0);
      end
      step(4'b0000, 1, 11'h057);
      chk("rel_nobypass", 32'(o_blk_addr_vld), 0);
      chk("rel_cnt", 32'(o_free_cnt), 1);
      step(4'b0000);
      chk("rel_gnt_vld", 32'(o_blk_addr_vld), 32'b0100);
      chk("rel_gnt_addr", 32'(o_blk_addr), 32'h050);
      for (int i = 0; i < 10; i++) step(4'b0000, 1, 11'((i + 1) * 16));
      chk("ten_cnt", 32'(o_free_cnt), 10);
      step(4'b0001);
      step(4'b0000, 1, 11'h7F0);
      chk("gr_vld", 32'(o_blk_addr_vld), 32'b0001);
      chk("gr_cnt", 32'(o_free_cnt), 10);
      chk("gr_err", 32'(o_err), 0);
      for (int i = 0; i < 118; i++) step(4'b0000, 1, 11'($urandom_range(0, 2047)));
      chk("full_cnt", 32'(o_free_cnt), 128);
      chk("full_err0", 32'(o_err), 0);
      step(4'b0000, 1, 11'h123);
      chk("ovf_cnt", 32'(o_free_cnt), 128);
      chk("ovf_err", 32'(o_err), 1);
      step(4'b0000);
      chk("ovf_sticky", 32'(o_err), 1);

      // duplicate request during init is merged into a single grant
      do_reset();
      for (int i = 0; i < 128; i++) begin
         step((i == 5 || i == 6) ? 4'b0010 : 4'b0000);
         if (i == 6) chk("dup_err", 32'(o_err), 1);
      end
      step(4'b0000);
      chk("dup_gnt", 32'(o_blk_addr_vld), 32'b0010);
      for (int i = 0; i < 3; i++) begin
         step(4'b0000);
         chk("dup_once", 32'(o_blk_addr_vld), 0);
      end

      // release during init, pending request, reset mid-init
      do_reset();
      step(4'b0000, 1, 11'h100);
      chk("init_rel_err", 32'(o_err), 1);
      step(4'b1000);
      for (int i = 2; i < 50; i++) step(4'b0000);
      do_reset();
      for (int i = 0; i < 128; i++) step(4'b0000);
      chk("rinit_cnt", 32'(o_free_cnt), 128);
      chk("rinit_err", 32'(o_err), 0);
      for (int i = 0; i < 4; i++) begin
         step(4'b0000);
         chk("rinit_nogrant", 32'(o_blk_addr_vld), 0);
      end

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         bit [3:0] r;
         r = '0;
         for (int p = 0; p < 4; p++) r[p] = $urandom_range(0, 3) == 0;
         step(r, $urandom_range(0, 9) < 3, 11'($urandom_range(0, 2047)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
